// File: rtl/bus_uart_pkg.sv
// Shared definitions for the bus-mapped UART transmitter: register map,
// STATUS bit positions and the transmit FSM state encoding.
package bus_uart_pkg;

    localparam logic [3:0] OFF_TXDATA  = 4'h0;
    localparam logic [3:0] OFF_STATUS  = 4'h4;
    localparam logic [3:0] OFF_BAUDDIV = 4'h8;

    // Only addr[3:2] selects a register, so decoding compares word indices.
    localparam logic [1:0] IDX_TXDATA  = OFF_TXDATA[3:2];
    localparam logic [1:0] IDX_STATUS  = OFF_STATUS[3:2];
    localparam logic [1:0] IDX_BAUDDIV = OFF_BAUDDIV[3:2];

    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter. A push at full is accepted only
// when a pop happens in the same cycle, so the caller never loses the head.
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             din,
    output logic [7:0]             dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/BAUDDIV register file,
// transmit FIFO and a four-state serializer with a programmable bit period.
module bus_uart_tx
    import bus_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int BAUD_RESET = 867
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] wData,
    output logic [31:0] rData,
    output logic        tx,
    output logic        txDone
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e     state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [15:0]   baud_cnt_q, baud_cnt_d;
    logic [15:0]   baud_cur_q, baud_cur_d;
    logic [15:0]   bauddiv_q, bauddiv_d;
    logic          ovf_q, ovf_d;
    logic          tx_q, tx_d;

    logic [1:0]    reg_idx;
    logic          wr_en, push_req, fifo_pop, bit_end;
    logic          fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          unused_bits;

    assign reg_idx     = addr[3:2];
    assign wr_en       = sel && we;
    assign push_req    = wr_en && (reg_idx == IDX_TXDATA);
    assign unused_bits = ^{addr[1:0], wData[31:16]};

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (fifo_pop),
        .din   (wData[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A dropped push sets overflow; a push that coincides with a pop is not a drop.
    always_comb begin
        bauddiv_d = bauddiv_q;
        ovf_d     = ovf_q;
        if (wr_en && (reg_idx == IDX_BAUDDIV)) begin
            bauddiv_d = wData[15:0];
        end
        if (push_req && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end else if (wr_en && (reg_idx == IDX_STATUS) && wData[STAT_OVF]) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        rData = '0;
        if (sel) begin
            case (reg_idx)
                IDX_STATUS: begin
                    rData[STAT_EMPTY] = fifo_empty;
                    rData[STAT_FULL]  = fifo_full;
                    rData[STAT_BUSY]  = (state_q != IDLE);
                    rData[STAT_OVF]   = ovf_q;
                    rData[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_count);
                end
                IDX_BAUDDIV: rData[15:0] = bauddiv_q;
                default:     rData = '0;
            endcase
        end
    end

    // baud_cur holds the divisor of the bit in flight, so a BAUDDIV write
    // only takes effect from the next bit boundary.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_cnt_q;
        baud_cur_d = baud_cur_q;
        fifo_pop   = 1'b0;
        bit_end    = (baud_cnt_q == baud_cur_q);

        if (state_q != IDLE) begin
            baud_cnt_d = bit_end ? 16'd0 : baud_cnt_q + 16'd1;
            if (bit_end) begin
                baud_cur_d = bauddiv_q;
            end
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_d    = fifo_dout;
                    state_d    = START;
                    baud_cnt_d = 16'd0;
                    baud_cur_d = bauddiv_q;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
            baud_cur_q <= 16'(BAUD_RESET);
            bauddiv_q  <= 16'(BAUD_RESET);
            ovf_q      <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            baud_cur_q <= baud_cur_d;
            bauddiv_q  <= bauddiv_d;
            ovf_q      <= ovf_d;
            tx_q       <= tx_d;
        end
    end

    assign tx     = tx_q;
    assign txDone = fifo_empty && (state_q == IDLE);

endmodule

// File: tb/tb_bus_uart_tx.sv
// Scoreboard bench for bus_uart_tx: stimulus queues expected frames, a
// line monitor decodes tx clock by clock and checks every bit period.
module tb_bus_uart_tx;

    logic        clk;
    logic        reset;
    logic        sel;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wData;
    logic [31:0] rData;
    logic        tx;
    logic        txDone;

    typedef struct {
        logic [7:0] data;
        int         len_a;
        int         len_b;
        int         switch_idx;
        bit         contiguous;
    } frame_t;

    frame_t sb[$];
    bit     mon_busy = 1'b0;
    int     checks_total = 0;
    int     checks_passed = 0;

    bus_uart_tx #(
        .FIFO_DEPTH (4),
        .BAUD_RESET (867)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .sel    (sel),
        .we     (we),
        .addr   (addr),
        .wData  (wData),
        .rData  (rData),
        .tx     (tx),
        .txDone (txDone)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [3:0] a, input logic [31:0] d);
        sel   = s;
        we    = 1'b1;
        addr  = a;
        wData = d;
        @(posedge clk);
        #1;
        sel   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wData = '0;
    endtask

    task automatic sendByte(input logic [7:0] b, input int la, input int lb, input int sw, input bit contig);
        frame_t f;
        f.data       = b;
        f.len_a      = la;
        f.len_b      = lb;
        f.switch_idx = sw;
        f.contiguous = contig;
        sb.push_back(f);
        applyStimulus(1'b1, 4'h0, {24'd0, b});
    endtask

    task automatic checkRead(input string name, input logic [3:0] a, input logic [31:0] expected);
        logic [31:0] d;
        sel  = 1'b1;
        we   = 1'b0;
        addr = a;
        #1;
        d    = rData;
        sel  = 1'b0;
        addr = '0;
        checkOutput(name, d, expected);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n = 0;
        while (!(sb.size() == 0 && !mon_busy && txDone === 1'b1) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({name, " frames drained"}, (sb.size() == 0 && !mon_busy) ? 32'd1 : 32'd0, 32'd1);
        checkOutput({name, " txDone"}, {31'd0, txDone}, 32'd1);
    endtask

    // Line monitor: a low level on an idle line starts the next queued frame;
    // each bit is compared on every clock of its expected duration.
    initial begin : monitor
        frame_t f;
        int     len;
        logic   exp_bit;
        logic   seen;
        bit     aborted;
        bit     more;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                sb.delete();
                continue;
            end
            if (tx === 1'b0) begin
                if (sb.size() == 0) begin
                    checkOutput("idle line level", {31'd0, tx}, 32'd1);
                end else begin
                    mon_busy = 1'b1;
                    aborted  = 1'b0;
                    do begin
                        f = sb.pop_front();
                        for (int i = 0; i < 10 && !aborted; i++) begin
                            len     = (i < f.switch_idx) ? f.len_a : f.len_b;
                            exp_bit = (i == 0) ? 1'b0 : ((i == 9) ? 1'b1 : f.data[i-1]);
                            seen    = 1'bx;
                            for (int c = 0; c < len; c++) begin
                                if (i != 0 || c != 0) @(negedge clk);
                                if (reset !== 1'b1) begin
                                    aborted = 1'b1;
                                    break;
                                end
                                if (c == 0 || tx !== exp_bit) seen = tx;
                            end
                            if (!aborted) begin
                                checkOutput($sformatf("frame 0x%02h bit %0d", f.data, i), {31'd0, seen}, {31'd0, exp_bit});
                            end
                        end
                        more = !aborted && (sb.size() > 0) && sb[0].contiguous;
                        if (more) @(negedge clk);
                    end while (more);
                    if (aborted) sb.delete();
                    mon_busy = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, %0d of %0d checks passed", checks_passed, checks_total);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int lows;
        reset = 1'b1;
        sel   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wData = '0;
        #1 reset = 1'b0;
        #1;
        checkOutput("tx in reset", {31'd0, tx}, 32'd1);
        checkOutput("txDone in reset", {31'd0, txDone}, 32'd1);
        waitCycles(3);
        reset = 1'b1;

        // Register map and decode boundaries after reset.
        checkRead("STATUS after reset", 4'h4, 32'h0000_0001);
        checkRead("BAUDDIV after reset", 4'h8, 32'd867);
        checkRead("TXDATA read", 4'h0, 32'h0);
        checkRead("offset 0xC read", 4'hC, 32'h0);
        sel  = 1'b0;
        we   = 1'b0;
        addr = 4'h8;
        #1;
        checkOutput("rData with sel=0", rData, 32'h0);
        addr = '0;
        applyStimulus(1'b0, 4'h0, 32'h0000_005A);
        checkRead("STATUS after unselected write", 4'h4, 32'h0000_0001);
        applyStimulus(1'b1, 4'hC, 32'hDEAD_BEEF);
        checkRead("offset 0xC after write", 4'hC, 32'h0);
        checkRead("BAUDDIV after 0xC write", 4'h8, 32'd867);
        applyStimulus(1'b1, 4'h8, 32'hFFFF_1234);
        checkRead("BAUDDIV upper bits", 4'h8, 32'h0000_1234);
        waitCycles(20);
        checkOutput("txDone with no traffic", {31'd0, txDone}, 32'd1);

        // Single 0xA5 frame at 4 clocks per bit.
        applyStimulus(1'b1, 4'h8, 32'd3);
        sendByte(8'hA5, 4, 4, 10, 1'b0);
        waitCycles(5);
        checkOutput("txDone mid-frame", {31'd0, txDone}, 32'd0);
        checkRead("STATUS mid-frame", 4'h4, 32'h0000_0005);
        waitIdle("A5 frame", 200);

        // Back-to-back frames at 2 clocks per bit, no gap between them.
        applyStimulus(1'b1, 4'h8, 32'd1);
        sendByte(8'h01, 2, 2, 10, 1'b0);
        sendByte(8'h02, 2, 2, 10, 1'b1);
        sendByte(8'h03, 2, 2, 10, 1'b1);
        checkRead("STATUS count 2", 4'h4, 32'h0000_0024);
        waitCycles(20);
        checkRead("STATUS count 1", 4'h4, 32'h0000_0014);
        waitCycles(20);
        checkRead("STATUS count 0", 4'h4, 32'h0000_0005);
        waitIdle("back-to-back", 200);

        // Overflow: one byte in flight, four queued, sixth dropped.
        applyStimulus(1'b1, 4'h8, 32'd100);
        sendByte(8'h10, 101, 101, 10, 1'b0);
        sendByte(8'h21, 101, 101, 10, 1'b1);
        sendByte(8'h32, 101, 101, 10, 1'b1);
        sendByte(8'h43, 101, 101, 10, 1'b1);
        sendByte(8'h54, 101, 101, 10, 1'b1);
        applyStimulus(1'b1, 4'h0, 32'h0000_0065);
        checkRead("STATUS full+overflow", 4'h4, 32'h0000_004E);
        applyStimulus(1'b1, 4'h4, 32'hFFFF_FFF7);
        checkRead("STATUS write without bit3", 4'h4, 32'h0000_004E);
        applyStimulus(1'b1, 4'h4, 32'h0000_0008);
        checkRead("STATUS overflow cleared", 4'h4, 32'h0000_0046);
        // Land a push exactly on the edge where the first STOP bit ends.
        waitCycles(1003);
        sendByte(8'h76, 101, 101, 10, 1'b1);
        checkRead("STATUS push+pop at full", 4'h4, 32'h0000_0046);
        waitIdle("overflow", 7000);

        // Divisor change during data bit 2 applies from data bit 3.
        applyStimulus(1'b1, 4'h8, 32'd3);
        sendByte(8'h55, 4, 8, 4, 1'b0);
        waitCycles(13);
        applyStimulus(1'b1, 4'h8, 32'd7);
        checkRead("BAUDDIV mid-frame write", 4'h8, 32'd7);
        waitIdle("baud change", 200);

        // Reset in the middle of a 0xFF frame aborts it for good.
        sendByte(8'hFF, 8, 8, 10, 1'b0);
        waitCycles(25);
        #2 reset = 1'b0;
        #1;
        checkOutput("tx async reset", {31'd0, tx}, 32'd1);
        checkOutput("txDone async reset", {31'd0, txDone}, 32'd1);
        checkRead("STATUS during reset", 4'h4, 32'h0000_0001);
        waitCycles(1);
        applyStimulus(1'b1, 4'h0, 32'h0000_0099);
        reset = 1'b1;
        checkRead("STATUS after abort", 4'h4, 32'h0000_0001);
        checkRead("BAUDDIV after abort", 4'h8, 32'd867);
        lows = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        checkOutput("tx low clocks after abort", lows, 32'd0);
        checkOutput("scoreboard empty at end", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/bus_uart_tx.md
BUS_UART_TX -- requirements
Module: bus_uart_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries (power of two, >= 2).
REQ-002 SHALL have parameter BAUD_RESET, default 867, reset value of BAUDDIV; bit period = BAUDDIV+1 clocks, giving 115200 baud at 100 MHz.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sel  input  1  chip select from the CPU bus address decoder.
REQ-006 SHALL have port we  input  1  bus write enable (CPU busWe).
REQ-007 SHALL have port addr  input  4  byte offset within the block; only addr[3:2] is decoded.
REQ-008 SHALL have port wData  input  32  bus write data.
REQ-009 SHALL have port rData  output  32  bus read data, combinational from addr.
REQ-010 SHALL have port tx  output  1  serial line, idle high.
REQ-011 SHALL have port txDone  output  1  high when FIFO is empty and FSM is IDLE.

Function
REQ-012 SHALL accept a write on the rising edge when sel && we, in a single cycle with no wait states.
REQ-013 SHALL map addr[3:2]=0 to TXDATA: a write pushes wData[7:0]; a read returns 0.
REQ-014 SHALL map addr[3:2]=1 to STATUS, read-only except bit3: bit0 empty, bit1 full, bit2 busy (state != IDLE), bit3 overflow (sticky), bits[7:4] FIFO count, all other bits 0.
REQ-015 SHALL clear overflow on a STATUS write with wData[3]=1 and ignore all other STATUS write bits.
REQ-016 SHALL map addr[3:2]=2 to BAUDDIV: 16-bit read/write in bits[15:0], upper read bits 0.
REQ-017 SHALL make addr[3:2]=3 read 0 and ignore writes to it.
REQ-018 SHALL return rData=0 when sel=0.
REQ-019 SHALL drop a TXDATA write while full with no simultaneous pop, and set overflow in that cycle.
REQ-020 SHALL accept the push on a simultaneous push and pop at full, leaving count unchanged and overflow untouched.
REQ-021 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-022 SHALL in IDLE drive tx=1; when the FIFO is non-empty, pop the head into the shift register and enter START on the next edge.
REQ-023 SHALL in START drive tx=0 for one bit period.
REQ-024 SHALL in DATA shift out 8 bits LSB first, one bit period each, tracked by a 3-bit bit counter.
REQ-025 SHALL in STOP drive tx=1 for one bit period; at its end, pop and go directly to START if the FIFO is non-empty (no idle gap), else go to IDLE.
REQ-026 SHALL implement the bit period with a 16-bit counter counting 0..BAUDDIV, reloading 0 at each bit boundary.
REQ-027 SHALL have a BAUDDIV write mid-frame take effect at the next bit boundary; the current bit completes with the old value.
REQ-028 SHALL produce a frame of exactly 10*(BAUDDIV+1) clocks.
REQ-029 SHALL have a FIFO read pointer and write pointer that wrap modulo FIFO_DEPTH, with count width clog2(FIFO_DEPTH)+1.

Reset
REQ-030 SHALL on reset=0 immediately set tx=1, state IDLE, FIFO empty (pointers and count 0), overflow 0, BAUDDIV=BAUD_RESET, bit and baud counters 0, txDone=1.
REQ-031 SHALL abort an in-flight frame on a mid-frame reset, with no resumption after release.
REQ-032 SHALL ignore bus writes while reset is low.

Structure
REQ-033 SHALL place register offsets (TXDATA, STATUS, BAUDDIV), STATUS bit indices and the FSM state enum in the shared package bus_uart_pkg.
REQ-034 SHALL implement the FIFO as sub-module uart_tx_fifo (push, pop, din, dout, full, empty, count), with the FSM and register file in bus_uart_tx.

Verification
REQ-035 SHALL cover: BAUDDIV=3, write TXDATA=0xA5 -> tx low 4 clocks, then bits 1,0,1,0,0,1,0,1 at 4 clocks each, high 4 clocks; frame 40 clocks; txDone returns to 1.
REQ-036 SHALL cover: BAUDDIV=1, 3 back-to-back writes 0x01,0x02,0x03 -> three frames of 20 clocks each, no idle cycles between STOP and next START, STATUS count decreasing 2,1,0.
REQ-037 SHALL cover: BAUDDIV=100, 6 writes with FIFO_DEPTH=4 -> first byte popped, 4 queued, 6th dropped, STATUS bit1=1 and bit3=1; write STATUS 0x8 -> bit3=0.
REQ-038 SHALL cover: BAUDDIV=3, write 0x55 then BAUDDIV=7 during bit 2 -> bit 2 lasts 4 clocks, bit 3 onward lasts 8 clocks.
REQ-039 SHALL cover: reset asserted mid-DATA of 0xFF -> tx=1 asynchronously, STATUS reads 0x1, BAUDDIV reads 867 after release.
REQ-040 SHALL cover: read offsets 0x0, 0xC and sel=0 -> rData=0; write 0x0 with sel=0 -> no push.
